// File: rtl/ball_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ball_pkg
// Description : Shared constants and the state encoding for the ping-pong
//               ball controller (ball_ctrl and score_keeper).
// Revision    : 1.0 - initial release
// ============================================================================
package ball_pkg;

   localparam int c_pos_w    = 9;   // ball position width, matches the tick counter
   localparam int c_score_w  = 4;   // per-player score width
   localparam int c_step_w   = 3;   // wide enough to hold the maximum step
   localparam int c_max_step = 4;   // fastest ball speed in positions per tick

   // FSM state codes as seen on the state output
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLY_R = 3'd1,
      ST_FLY_L = 3'd2,
      ST_MISS  = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : score_keeper
// Description : Two saturating score registers, the server flag and the
//               game-won compare. Scores and server clear together when a
//               finished game is restarted.
// Revision    : 1.0 - initial release
// ============================================================================
module score_keeper
   import ball_pkg::*;
#(
   parameter int WIN_SCORE = 11
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 award_l,
   input  logic                 award_r,
   input  logic                 toggle_srv,
   input  logic                 clear,
   output logic [c_score_w-1:0] score_l,
   output logic [c_score_w-1:0] score_r,
   output logic                 server,
   output logic                 win
);

   localparam logic [c_score_w-1:0] c_win = c_score_w'(WIN_SCORE);

   logic [c_score_w-1:0] score_l_q, score_l_d;
   logic [c_score_w-1:0] score_r_q, score_r_d;
   logic                 server_q,  server_d;

   // Next scores: clear has priority, otherwise saturating increments
   always_comb begin
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      server_d  = server_q;
      if (clear) begin
         score_l_d = '0;
         score_r_d = '0;
         server_d  = 1'b0;
      end else begin
         if (award_l && (score_l_q < c_win)) score_l_d = score_l_q + c_score_w'(1);
         if (award_r && (score_r_q < c_win)) score_r_d = score_r_q + c_score_w'(1);
         if (toggle_srv)                     server_d  = ~server_q;
      end
   end

   // Score and server registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         score_l_q <= '0;
         score_r_q <= '0;
         server_q  <= 1'b0;
      end else begin
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         server_q  <= server_d;
      end
   end

   assign score_l = score_l_q;
   assign score_r = score_r_q;
   assign server  = server_q;
   assign win     = (score_l_q >= c_win) || (score_r_q >= c_win);

endmodule
`default_nettype wire

// File: rtl/ball_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ball_ctrl
// Description : Ball trajectory and scoring FSM. Moves the ball one step per
//               movement tick, accepts paddle hits inside each end's hit
//               window, awards points on misses and ends the game at
//               WIN_SCORE.
// Options     : BALL_SPEEDUP_EN - step grows by one per accepted hit (max 4),
//               restarting at 1 on each serve. Undefined: constant step 1.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_ctrl
   import ball_pkg::*;
#(
   parameter int POS_W     = c_pos_w,
   parameter int TABLE_LEN = 320,
   parameter int HIT_WIN   = 16,
   parameter int MISS_HOLD = 50,
   parameter int WIN_SCORE = 11
)(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tick,
   input  logic                 serve,
   input  logic                 hit_l,
   input  logic                 hit_r,
   output logic [POS_W-1:0]     ball_pos,
   output logic                 ball_dir,
   output logic [2:0]           state,
   output logic [c_score_w-1:0] score_l,
   output logic [c_score_w-1:0] score_r,
   output logic                 miss_pulse,
   output logic                 game_over
);

   localparam int                  c_hold_w    = $clog2(MISS_HOLD + 1);
   localparam logic [POS_W-1:0]    c_last      = POS_W'(TABLE_LEN - 1);
   localparam logic [POS_W-1:0]    c_win_r     = POS_W'(TABLE_LEN - 1 - HIT_WIN);
   localparam logic [POS_W-1:0]    c_win_l     = POS_W'(HIT_WIN);
   localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MISS_HOLD - 1);

   state_e               state_q, state_d;
   logic [POS_W-1:0]     pos_q,   pos_d;
   logic                 dir_q,   dir_d;
   logic                 miss_q,  miss_d;
   logic                 over_q,  over_d;
   logic [c_hold_w-1:0]  hold_q,  hold_d;

   logic                 award_l, award_r, toggle_srv, clear_scores;
   logic                 server, win;
   logic                 hit_ok_r, hit_ok_l, launch;
   logic [c_step_w-1:0]  step;
   logic [POS_W:0]       pos_up;
   logic [POS_W-1:0]     pos_dn;

`ifdef BALL_SPEEDUP_EN
   logic [c_step_w-1:0]  step_q, step_d;
   localparam logic [c_step_w-1:0] c_step_max = c_step_w'(c_max_step);

   // Step restarts on every serve and grows on each accepted hit
   always_comb begin
      step_d = step_q;
      if (launch)
         step_d = c_step_w'(1);
      else if ((hit_ok_r || hit_ok_l) && (step_q < c_step_max))
         step_d = step_q + c_step_w'(1);
   end

   // Step register
   always_ff @(posedge clk) begin
      if (!rst_n) step_q <= c_step_w'(1);
      else        step_q <= step_d;
   end

   assign step = step_q;
`else
   assign step = c_step_w'(1);
`endif

   // Hits only count inside the window of the end the ball is heading to
   assign hit_ok_r = (state_q == ST_FLY_R) && hit_r && (pos_q >= c_win_r);
   assign hit_ok_l = (state_q == ST_FLY_L) && hit_l && (pos_q <= c_win_l);
   assign launch   = (state_q == ST_IDLE)  && serve;

   // Clamped candidate positions; the extra bit on pos_up catches overshoot
   assign pos_up = {1'b0, pos_q} + (POS_W+1)'(step);
   assign pos_dn = (pos_q <= POS_W'(step)) ? '0 : (pos_q - POS_W'(step));

   // Next-state, ball motion and score events
   always_comb begin
      state_d      = state_q;
      pos_d        = pos_q;
      dir_d        = dir_q;
      hold_d       = hold_q;
      miss_d       = 1'b0;
      award_l      = 1'b0;
      award_r      = 1'b0;
      toggle_srv   = 1'b0;
      clear_scores = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pos_d = server ? c_last : '0;
            dir_d = server;
            if (launch) state_d = server ? ST_FLY_L : ST_FLY_R;
         end
         ST_FLY_R: begin
            if (hit_ok_r) begin
               state_d = ST_FLY_L;
               dir_d   = 1'b1;
            end else if (tick) begin
               if (pos_q == c_last) begin
                  state_d = ST_MISS;
                  award_l = 1'b1;
                  miss_d  = 1'b1;
                  hold_d  = '0;
               end else begin
                  pos_d = (pos_up > {1'b0, c_last}) ? c_last : pos_up[POS_W-1:0];
               end
            end
         end
         ST_FLY_L: begin
            if (hit_ok_l) begin
               state_d = ST_FLY_R;
               dir_d   = 1'b0;
            end else if (tick) begin
               if (pos_q == '0) begin
                  state_d = ST_MISS;
                  award_r = 1'b1;
                  miss_d  = 1'b1;
                  hold_d  = '0;
               end else begin
                  pos_d = pos_dn;
               end
            end
         end
         ST_MISS: begin
            if (tick) begin
               if (hold_q == c_hold_last) begin
                  hold_d = '0;
                  if (win) begin
                     state_d = ST_OVER;
                  end else begin
                     // Server flips; park the ball at the new server's end now
                     state_d    = ST_IDLE;
                     toggle_srv = 1'b1;
                     pos_d      = server ? '0 : c_last;
                     dir_d      = ~server;
                  end
               end else begin
                  hold_d = hold_q + c_hold_w'(1);
               end
            end
         end
         ST_OVER: begin
            if (serve) begin
               clear_scores = 1'b1;
               state_d      = ST_IDLE;
               pos_d        = '0;
               dir_d        = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      over_d = (state_d == ST_OVER);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pos_q   <= '0;
         dir_q   <= 1'b0;
         miss_q  <= 1'b0;
         over_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         dir_q   <= dir_d;
         miss_q  <= miss_d;
         over_q  <= over_d;
         hold_q  <= hold_d;
      end
   end

   score_keeper #(
      .WIN_SCORE (WIN_SCORE)
   ) u_score_keeper (
      .clk        (clk),
      .rst_n      (rst_n),
      .award_l    (award_l),
      .award_r    (award_r),
      .toggle_srv (toggle_srv),
      .clear      (clear_scores),
      .score_l    (score_l),
      .score_r    (score_r),
      .server     (server),
      .win        (win)
   );

   assign ball_pos   = pos_q;
   assign ball_dir   = dir_q;
   assign state      = state_q;
   assign miss_pulse = miss_q;
   assign game_over  = over_q;

endmodule
`default_nettype wire
